// File: rtl/delta_decoder_8b_pkg.sv
// Shared types and constants for the delta decoder.
// Defines the decoder state encoding and the default sample width.
package delta_pkg;
  localparam int P_DELTA_NBITS = 8;

  typedef enum logic {
    SEED = 1'b0,
    RUN  = 1'b1
  } delta_state_e;
endpackage

// File: rtl/delta_decoder_8b_if.sv
// Delta input stream and sample output stream of the decoder.
// Each stream uses a val/rdy handshake; restart travels with the input beat.
interface delta_decoder_8b_if
  import delta_pkg::*;
#(
  parameter int p_nbits = P_DELTA_NBITS
);
  logic               istream_val;
  logic               istream_rdy;
  logic [p_nbits-1:0] istream_msg;
  logic               restart;
  logic               ostream_val;
  logic               ostream_rdy;
  logic [p_nbits-1:0] ostream_msg;

  modport master (
    output istream_val, istream_msg, restart, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );

  modport slave (
    input  istream_val, istream_msg, restart, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );
endinterface

// File: rtl/delta_decoder_8b_add.sv
// Combinational next-accumulator: seed passthrough or ripple add of acc + delta.
// With DELTA_DECODER_SAT_EN the delta is signed and the result clamps to [0, max].
module delta_add
  import delta_pkg::*;
#(
  parameter int p_nbits = P_DELTA_NBITS
) (
  input  logic [p_nbits-1:0] acc,
  input  logic [p_nbits-1:0] delta,
  input  logic               seed,
  output logic [p_nbits-1:0] next
);
  logic [p_nbits-1:0] w_sum;
`ifdef DELTA_DECODER_SAT_EN
  logic w_cout;
`endif

  always_comb begin : ripple
    logic carry;
    carry = 1'b0;
    w_sum = '0;
    for (int i = 0; i < p_nbits; i++) begin
      w_sum[i] = acc[i] ^ delta[i] ^ carry;
      carry    = (acc[i] & delta[i]) | (carry & (acc[i] ^ delta[i]));
    end
`ifdef DELTA_DECODER_SAT_EN
    w_cout = carry;
`endif
  end

`ifdef DELTA_DECODER_SAT_EN
  // Unsigned acc plus signed delta: a carry with a positive delta overflows,
  // no carry with a negative delta underflows.
  always_comb begin
    next = w_sum;
    if (seed) begin
      next = delta;
    end else if (!delta[p_nbits-1] && w_cout) begin
      next = '1;
    end else if (delta[p_nbits-1] && !w_cout) begin
      next = '0;
    end
  end
`else
  assign next = seed ? delta : w_sum;
`endif
endmodule

// File: rtl/delta_decoder_8b.sv
// Delta stream integrator: FSM, accumulator and one-deep output buffer.
// Clamping arithmetic is selected by DELTA_DECODER_SAT_EN in delta_add.
module delta_decoder_8b
  import delta_pkg::*;
#(
  parameter int p_nbits = P_DELTA_NBITS
) (
  input  logic               clk,
  input  logic               rst,
  delta_decoder_8b_if.slave  io
);
  delta_state_e       r_state;
  delta_state_e       w_state_nxt;
  logic [p_nbits-1:0] r_acc;
  logic [p_nbits-1:0] w_acc_nxt;
  logic [p_nbits-1:0] w_add;
  logic               r_out_val;
  logic               w_out_val_nxt;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_seed;

  assign io.istream_rdy = !rst && (!r_out_val || io.ostream_rdy);
  assign w_in_fire      = io.istream_val && io.istream_rdy;
  assign w_out_fire     = r_out_val && io.ostream_rdy;
  assign w_seed         = (r_state == SEED) || io.restart;

  delta_add #(.p_nbits(p_nbits)) u_add (
    .acc   (r_acc),
    .delta (io.istream_msg),
    .seed  (w_seed),
    .next  (w_add)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_out_val_nxt = r_out_val;
    if (w_in_fire) begin
      w_state_nxt   = RUN;
      w_acc_nxt     = w_add;
      w_out_val_nxt = 1'b1;
    end else if (w_out_fire) begin
      w_out_val_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SEED;
      r_acc     <= '0;
      r_out_val <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_out_val <= w_out_val_nxt;
    end
  end

  // The output buffer always equals the accumulator, so it shares the register.
  assign io.ostream_val = r_out_val;
  assign io.ostream_msg = r_acc;
endmodule

// File: tb/tb_delta_decoder_8b.sv
// Scoreboard bench for delta_decoder_8b: accepted inputs queue the expected
// sample, a monitor pops and compares on every output handshake.
module tb_delta_decoder_8b;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [7:0] sb[$];

  delta_decoder_8b_if io ();

  delta_decoder_8b dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any handshake that completes at the next rising edge is checked here.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && io.ostream_val === 1'b1 && io.ostream_rdy === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%02h required=none", io.ostream_msg);
        end else begin
          chk("sb_out", io.ostream_msg, sb.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] m, input logic rs, input logic [7:0] exp);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    io.istream_val = 1'b1;
    io.istream_msg = m;
    io.restart     = rs;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (io.istream_rdy === 1'b1) ok = 1;
      else n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted msg=%02h", m);
    end else begin
      @(posedge clk);
      sb.push_back(exp);
      #1;
      chk("lat_val", {7'd0, io.ostream_val}, 8'd1);
      chk("lat_msg", io.ostream_msg, exp);
    end
    io.istream_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    io.istream_val = 1'b0;
    io.istream_msg = 8'h00;
    io.restart     = 1'b0;
    io.ostream_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_oval", {7'd0, io.ostream_val}, 8'd0);
    chk("rst_omsg", io.ostream_msg, 8'h00);
    chk("rst_irdy", {7'd0, io.istream_rdy}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    io.ostream_rdy = 1'b1;

    // Basic stream
    send(8'h10, 1'b0, 8'h10);
    send(8'h05, 1'b0, 8'h15);
    send(8'hFE, 1'b0, 8'h13);

    // Wrap / high clamp
`ifdef DELTA_DECODER_SAT_EN
    send(8'hFE, 1'b1, 8'hFE);
    send(8'h01, 1'b0, 8'hFF);
    send(8'h01, 1'b0, 8'hFF);
    send(8'h03, 1'b0, 8'hFF);
    send(8'h10, 1'b1, 8'h10);
    send(8'hE0, 1'b0, 8'h00);
    send(8'h7F, 1'b0, 8'h7F);
`else
    send(8'hFE, 1'b1, 8'hFE);
    send(8'h01, 1'b0, 8'hFF);
    send(8'h01, 1'b0, 8'h00);
    send(8'h03, 1'b0, 8'h03);
    send(8'h10, 1'b1, 8'h10);
    send(8'hE0, 1'b0, 8'hF0);
    send(8'h7F, 1'b0, 8'h6F);
`endif
    repeat (2) @(posedge clk);
    #1;

    // Backpressure
    io.ostream_rdy = 1'b0;
    send(8'h20, 1'b1, 8'h20);
    io.istream_val = 1'b1;
    io.istream_msg = 8'h04;
    io.restart     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_irdy", {7'd0, io.istream_rdy}, 8'd0);
      chk("bp_oval", {7'd0, io.ostream_val}, 8'd1);
      chk("bp_omsg", io.ostream_msg, 8'h20);
    end
    @(posedge clk);
    #1;
    io.ostream_rdy = 1'b1;
    send(8'h04, 1'b0, 8'h24);
    repeat (2) @(posedge clk);
    #1;

    // Restart
    send(8'h10, 1'b1, 8'h10);
    send(8'h01, 1'b0, 8'h11);
    send(8'h80, 1'b1, 8'h80);
    send(8'h02, 1'b0, 8'h82);
    repeat (2) @(posedge clk);
    #1;

    // Mid-stream reset discards the buffered sample
    io.ostream_rdy = 1'b0;
    send(8'h55, 1'b1, 8'h55);
    void'(sb.pop_back());
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_irdy", {7'd0, io.istream_rdy}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_oval", {7'd0, io.ostream_val}, 8'd0);
    io.ostream_rdy = 1'b1;
    send(8'h07, 1'b0, 8'h07);
    send(8'h01, 1'b0, 8'h08);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delta_decoder_8b.md
Name: delta_decoder_8b

Overview:
- Streaming integrator: reconstructs absolute 8-bit samples from a stream of 8-bit differences, where each difference is current minus previous, modulo 256.
- Inverse of the team's subtractor-based delta encoder. Sits on the receive side of the delta-coded datapath.
- Uses val/rdy handshakes on both sides and one output buffer stage.
- The first delta after reset, or after a restart, carries the absolute seed value.

Parameters:
- p_nbits, 8, sample and delta width in bits. All arithmetic is modulo 2^p_nbits.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- restart  input  1  sampled only on an accepted input; marks that input as a new absolute seed
- istream_val  input  1  delta valid
- istream_rdy  output  1  decoder can accept a delta
- istream_msg  input  p_nbits  delta, or seed when the state is SEED or restart=1
- ostream_val  output  1  reconstructed sample valid
- ostream_rdy  input  1  consumer accepts the sample
- ostream_msg  output  p_nbits  reconstructed sample

Behaviour:
- Reset and clock: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a clock edge:
  - state <= SEED, acc <= 0, ostream_val <= 0, ostream_msg <= 0.
  - istream_rdy is 0 during any cycle in which rst=1.
- Handshake:
  - in_fire = istream_val & istream_rdy.
  - out_fire = ostream_val & ostream_rdy.
  - istream_rdy = !ostream_val | ostream_rdy. This gives full throughput when the consumer is ready and is combinational from ostream_rdy only.
  - istream_rdy never depends on istream_val.
- Latency: a sample accepted at edge N appears on ostream at N+1 and stays stable until out_fire.
- FSM states:
  - SEED, on in_fire: acc <= istream_msg, out <= istream_msg, next state RUN. restart is ignored.
  - RUN, on in_fire with restart=0: acc <= acc + istream_msg, carry dropped. out <= the same value. Stay in RUN.
  - RUN, on in_fire with restart=1: behaves as SEED; the message is an absolute value. Stay in RUN.
  - No in_fire: acc and state hold.
- Output buffer:
  - in_fire sets ostream_val=1.
  - out_fire without in_fire clears it.
  - in_fire and out_fire in the same cycle: the buffer is overwritten and ostream_val stays 1.
  - ostream_msg changes only on in_fire.
- Wrap-around: 0xFF + 0x01 = 0x00, and 0x00 + 0xFF = 0xFF, i.e. a delta of -1. No flag is raised.
- Backpressure: when ostream_rdy=0 and ostream_val=1, istream_rdy=0 and no delta is lost. acc is not advanced for unaccepted inputs.
- Reset mid-stream: the buffered sample is discarded (ostream_val=0 the next cycle). The next accepted input is treated as a seed.
- X safety: istream_msg and restart are don't-care when istream_val=0.

Optional Feature:
- Macro: DELTA_DECODER_SAT_EN
- Defined:
  - In RUN without restart, istream_msg is a signed two's-complement delta in the range -2^(p_nbits-1) to 2^(p_nbits-1)-1.
  - acc is unsigned, and acc + delta is clamped to the range 0 to 2^p_nbits-1.
  - Example: 0xF0 + 0x20 gives 0xFF. 0x10 + 0xE0 (-32) gives 0x00.
  - Seed behaviour is unchanged.
- Undefined: modulo-2^p_nbits wrap as described above. No clamp logic is instantiated.

Decomposition:
- Shared package delta_pkg: state enum {SEED, RUN}, 1-bit encoding, plus the constant P_DELTA_NBITS=8.
- Sub-module delta_add:
  - Combinational.
  - Inputs: acc, delta, seed. Output: next.
  - Contains the p_nbits ripple adder and, under DELTA_DECODER_SAT_EN, the sign/overflow clamp.
- The top level holds the FSM, acc register and output buffer.

Test Plan:
- Reset, then seed 0x10 and deltas 0x05, 0xFE with ostream_rdy=1 held -> outputs 0x10, 0x15, 0x13 on consecutive cycles, one cycle after each accept.
- Wrap: seed 0xFE, deltas 0x01, 0x01, 0x03 -> 0xFF, 0x00, 0x03. With DELTA_DECODER_SAT_EN: 0xFF, 0xFF, 0xFF, since the signed +1 clamps at the maximum.
- Backpressure: seed 0x20 accepted, ostream_rdy=0 for 3 cycles while istream_val=1 with delta 0x04 -> istream_rdy=0, ostream_msg=0x20 held. After ostream_rdy=1, outputs 0x20 then 0x24 with no loss and no duplication.
- Restart: stream 0x10, +0x01 gives 0x11. Then restart=1 with msg 0x80 -> 0x80. Then delta 0x02 -> 0x82.
- Mid-stream reset: rst pulse while ostream_val=1 holding 0x55 -> ostream_val=0 the next cycle. Next input 0x07 -> output 0x07 (seed).
- Saturation low, with DELTA_DECODER_SAT_EN: seed 0x10, delta 0xE0 -> 0x00. Then delta 0x7F -> 0x7F.
